// File: rtl/md_issue_ctrl.sv
// Issue controller between the integer pipeline and the mul/div/sign-inject unit.
// Captures one op, drives the request channel, drains the response and writes it back.
module md_issue_ctrl #(
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [OP_W-1:0] issue_op,
  input  logic [2:0]      issue_rm,
  input  logic            issue_in_1_signed,
  input  logic            issue_in_2_signed,
  input  logic            issue_out_sel,
  input  logic [4:0]      issue_rd,
  input  logic [31:0]     issue_in_1,
  input  logic [31:0]     issue_in_2,
  input  logic            kill,
  output logic            stall,
  output logic            md_req_valid,
  input  logic            md_req_ready,
  output logic [OP_W-1:0] md_req_op,
  output logic [2:0]      md_req_rm,
  output logic            md_req_in_1_signed,
  output logic            md_req_in_2_signed,
  output logic            md_req_out_sel,
  output logic [31:0]     md_req_in_1,
  output logic [31:0]     md_req_in_2,
  input  logic            md_resp_valid,
  input  logic [31:0]     md_resp_result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [31:0]     wb_data,
  output logic            busy,
  output logic            timeout_err,
  output logic [1:0]      state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t           state;
  logic             killed;
  logic [CNT_W-1:0] cnt;

  // Request channel: a transfer happens on any cycle with md_req_valid & md_req_ready;
  // while valid is high and ready is low the md_req_* fields do not change.
  assign stall     = (state == REQ) | (state == WAIT) | ((state == IDLE) & issue_valid & ~kill);
  assign wb_valid  = (state == DONE) & ~killed & ~kill;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      killed             <= 1'b0;
      cnt                <= '0;
      md_req_valid       <= 1'b0;
      md_req_op          <= '0;
      md_req_rm          <= '0;
      md_req_in_1_signed <= 1'b0;
      md_req_in_2_signed <= 1'b0;
      md_req_out_sel     <= 1'b0;
      md_req_in_1        <= '0;
      md_req_in_2        <= '0;
      wb_rd              <= '0;
      wb_data            <= '0;
      busy               <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid & ~kill) begin
            md_req_op          <= issue_op;
            md_req_rm          <= issue_rm;
            md_req_in_1_signed <= issue_in_1_signed;
            md_req_in_2_signed <= issue_in_2_signed;
            md_req_out_sel     <= issue_out_sel;
            md_req_in_1        <= issue_in_1;
            md_req_in_2        <= issue_in_2;
            wb_rd              <= issue_rd;
            killed             <= 1'b0;
            md_req_valid       <= 1'b1;
            busy               <= 1'b1;
            state              <= REQ;
          end
        end
        REQ: begin
          // A kill coincident with ready still transfers, so the response must be drained.
          if (md_req_ready) begin
            md_req_valid <= 1'b0;
            cnt          <= '0;
            if (kill) killed <= 1'b1;
            state        <= WAIT;
          end else if (kill) begin
            md_req_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        WAIT: begin
          if (kill) killed <= 1'b1;
          if (md_resp_valid) begin
            wb_data <= md_resp_result;
            state   <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            killed      <= 1'b1;
            state       <= DONE;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
